// File: rtl/alu_wrapper_pkg.sv
// Shared definitions for the ALU wrapper: default width, op encodings and
// shift-amount width.
package alu_wrapper_pkg;

  localparam int WIDTH_DEFAULT = 64;
  localparam int OP_W          = 4;
  localparam int SHAMT_W       = 6;

  localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB  = 4'b0001;
  localparam logic [OP_W-1:0] OP_AND  = 4'b0010;
  localparam logic [OP_W-1:0] OP_OR   = 4'b0011;
  localparam logic [OP_W-1:0] OP_XOR  = 4'b0100;
  localparam logic [OP_W-1:0] OP_SRL  = 4'b0101;
  localparam logic [OP_W-1:0] OP_SLL  = 4'b0110;
  localparam logic [OP_W-1:0] OP_SRA  = 4'b0111;
  localparam logic [OP_W-1:0] OP_SLT  = 4'b1000;
  localparam logic [OP_W-1:0] OP_SLTU = 4'b1001;

endpackage

// File: rtl/alu64_core.sv
// Combinational ALU datapath: one shared add/subtract unit (also used for the
// compares) and one right-only barrel shifter (left shifts via bit reversal).
module alu64_core
  import alu_wrapper_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] y
);

  // ---------------------------------------------------------------------
  // Adder: every op except ADD wants a-b (SUB result, compare flags), so
  // subtract mode is simply "not ADD"; other ops ignore the adder output.
  // ---------------------------------------------------------------------
  logic             sub_mode;
  logic [WIDTH:0]   sum_full;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             lt_unsigned;
  logic             lt_signed;

  assign sub_mode = (op != OP_ADD);
  assign sum_full = {1'b0, a} + {1'b0, b ^ {WIDTH{sub_mode}}}
                  + {{WIDTH{1'b0}}, sub_mode};
  assign sum      = sum_full[WIDTH-1:0];
  assign carry    = sum_full[WIDTH];

  // a-b produces no carry-out exactly when a < b unsigned.
  assign lt_unsigned = ~carry;
  // With differing signs the negative operand is smaller; with equal signs
  // the difference cannot overflow, so its sign bit answers directly.
  assign lt_signed   = (a[WIDTH-1] ^ b[WIDTH-1]) ? a[WIDTH-1] : sum[WIDTH-1];

  // ---------------------------------------------------------------------
  // Shifter: log-depth right shifter. SLL reverses the operand on the way
  // in and out; SRA fills with the sign bit, SRL/SLL fill with zero.
  // ---------------------------------------------------------------------
  logic [SHAMT_W-1:0]          shamt;
  logic                        is_sll;
  logic                        fill;
  logic [WIDTH-1:0]            a_rev;
  logic [WIDTH-1:0]            shr_out;
  logic [WIDTH-1:0]            shl_out;
  logic [SHAMT_W:0][WIDTH-1:0] stage;

  assign shamt  = b[SHAMT_W-1:0];
  assign is_sll = (op == OP_SLL);
  assign fill   = (op == OP_SRA) & a[WIDTH-1];

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_rev
      assign a_rev[gi]   = a[WIDTH-1-gi];
      assign shl_out[gi] = shr_out[WIDTH-1-gi];
    end

    assign stage[0] = is_sll ? a_rev : a;

    for (gi = 0; gi < SHAMT_W; gi++) begin : g_shift
      localparam int SH = 1 << gi;
      assign stage[gi+1] = shamt[gi]
                         ? {{SH{fill}}, stage[gi][WIDTH-1:SH]}
                         : stage[gi];
    end
  endgenerate

  assign shr_out = stage[SHAMT_W];

  // Result select; reserved encodings give zero.
  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = sum;
      OP_SUB:  y = sum;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SRL:  y = shr_out;
      OP_SLL:  y = shl_out;
      OP_SRA:  y = shr_out;
      OP_SLT:  y = {{(WIDTH-1){1'b0}}, lt_signed};
      OP_SLTU: y = {{(WIDTH-1){1'b0}}, lt_unsigned};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_wrapper.sv
// Registered ALU: combinational core followed by a single result register
// with synchronous active-low clear. One-cycle latency, one op per cycle.
module alu_wrapper
  import alu_wrapper_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] core_y;

  alu64_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a  (a),
    .b  (b),
    .op (op),
    .y  (core_y)
  );

  // Capture the core output each edge; reset drops any in-flight value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result <= '0;
    end else begin
      result <= core_y;
    end
  end

endmodule

// File: tb/tb_alu_wrapper.sv
// Self-checking bench for alu_wrapper: directed vectors, reset boundaries,
// then randomized ops with occasional mid-stream reset against a model.
module tb_alu_wrapper;

  logic        clk;
  logic        rst_n;
  logic [63:0] a;
  logic [63:0] b;
  logic [3:0]  op;
  logic [63:0] result;

  int checks;
  int errors;

  logic [63:0] prev_exp;
  bit          prev_valid;

  alu_wrapper #(
    .WIDTH (64)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .op     (op),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model written straight from the op table.
  function automatic logic [63:0] ref_alu(input logic [3:0] f_op,
                                          input logic [63:0] f_a,
                                          input logic [63:0] f_b);
    logic [5:0]  sh;
    logic [63:0] r;
    sh = f_b[5:0];
    case (f_op)
      4'd0:    r = f_a + f_b;
      4'd1:    r = f_a - f_b;
      4'd2:    r = f_a & f_b;
      4'd3:    r = f_a | f_b;
      4'd4:    r = f_a ^ f_b;
      4'd5:    r = f_a >> sh;
      4'd6:    r = f_a << sh;
      4'd7:    r = 64'($signed(f_a) >>> sh);
      4'd8:    r = ($signed(f_a) < $signed(f_b)) ? 64'd1 : 64'd0;
      4'd9:    r = (f_a < f_b) ? 64'd1 : 64'd0;
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  // One cycle: drive on the falling edge, confirm the previous result is
  // still held, then check the new result just after the rising edge.
  task automatic step(input string tag, input logic rst_val, input logic [3:0] s_op,
                      input logic [63:0] s_a, input logic [63:0] s_b);
    logic [63:0] exp;
    @(negedge clk);
    rst_n = rst_val;
    op    = s_op;
    a     = s_a;
    b     = s_b;
    #1;
    if (prev_valid) check_val({tag, "_hold"}, result, prev_exp);
    exp = rst_val ? ref_alu(s_op, s_a, s_b) : 64'd0;
    @(posedge clk);
    #1;
    check_val(tag, result, exp);
    $display("op=%h a=%h b=%h rst_n=%0d result=%h exp=%h", s_op, s_a, s_b,
             rst_val, result, exp);
    prev_exp   = exp;
    prev_valid = 1'b1;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    prev_valid = 1'b0;
    prev_exp   = 64'd0;
    rst_n      = 1'b0;
    op         = 4'd0;
    a          = 64'd0;
    b          = 64'd0;

    // Reset must clear regardless of inputs.
    step("reset0", 1'b0, 4'd0, 64'h1234, 64'h5678);
    step("reset1", 1'b0, 4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);

    // Directed vectors with hand-derived expectations.
    step("add_ovf", 1'b1, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    check_val("add_ovf_k", result, 64'h8000_0000_0000_0000);
    step("add_neg", 1'b1, 4'd0, -64'sd10, 64'd15);
    check_val("add_neg_k", result, 64'd5);
    step("sub_neg", 1'b1, 4'd1, 64'd10, 64'd20);
    check_val("sub_neg_k", result, 64'hFFFF_FFFF_FFFF_FFF6);
    step("sub_wrap", 1'b1, 4'd1, 64'h8000_0000_0000_0000, 64'd1);
    check_val("sub_wrap_k", result, 64'h7FFF_FFFF_FFFF_FFFF);
    step("and", 1'b1, 4'd2, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555);
    check_val("and_k", result, 64'd0);
    step("or", 1'b1, 4'd3, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555);
    check_val("or_k", result, 64'hFFFF_FFFF_FFFF_FFFF);
    step("xor", 1'b1, 4'd4, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555);
    check_val("xor_k", result, 64'hFFFF_FFFF_FFFF_FFFF);
    step("srl1", 1'b1, 4'd5, 64'h8000_0000_0000_0000, 64'd1);
    check_val("srl1_k", result, 64'h4000_0000_0000_0000);
    step("sra1", 1'b1, 4'd7, 64'h8000_0000_0000_0000, 64'd1);
    check_val("sra1_k", result, 64'hC000_0000_0000_0000);
    step("sll4", 1'b1, 4'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'd4);
    check_val("sll4_k", result, 64'hFFFF_FFFF_FFFF_FFF0);
    step("srl8", 1'b1, 4'd5, 64'h1234_5678_90AB_CDEF, 64'd8);
    check_val("srl8_k", result, 64'h0012_3456_7890_ABCD);
    step("sll0_hi", 1'b1, 4'd6, 64'h1234_5678_90AB_CDEF, 64'hFFFF_FFFF_FFFF_FFC0);
    check_val("sll0_hi_k", result, 64'h1234_5678_90AB_CDEF);
    step("sra63", 1'b1, 4'd7, 64'h8000_0000_0000_0000, 64'd63);
    check_val("sra63_k", result, 64'hFFFF_FFFF_FFFF_FFFF);
    step("slt_neg", 1'b1, 4'd8, -64'sd10, 64'd5);
    check_val("slt_neg_k", result, 64'd1);
    step("sltu_neg", 1'b1, 4'd9, -64'sd10, 64'd5);
    check_val("sltu_neg_k", result, 64'd0);
    step("slt_max", 1'b1, 4'd8, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000);
    check_val("slt_max_k", result, 64'd0);
    step("sltu_max", 1'b1, 4'd9, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000);
    check_val("sltu_max_k", result, 64'd1);
    step("slt_eq", 1'b1, 4'd8, 64'd0, 64'd0);
    check_val("slt_eq_k", result, 64'd0);
    step("sltu_eq", 1'b1, 4'd9, 64'd0, 64'd0);
    check_val("sltu_eq_k", result, 64'd0);

    // Mid-stream reset discards the in-flight ADD, release recomputes it.
    step("add_pre", 1'b1, 4'd0, 64'd1, 64'd2);
    step("mid_rst", 1'b0, 4'd0, 64'd10, 64'd20);
    check_val("mid_rst_k", result, 64'd0);
    step("rel_add", 1'b1, 4'd0, 64'd10, 64'd20);
    check_val("rel_add_k", result, 64'd30);
    step("op_f", 1'b1, 4'hF, 64'hDEAD_BEEF_0000_0001, 64'h1);
    check_val("op_f_k", result, 64'd0);
    step("op_a", 1'b1, 4'hA, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    check_val("op_a_k", result, 64'd0);

    // Randomized back-to-back traffic with sporadic reset cycles.
    for (int i = 0; i < 400; i++) begin
      logic [63:0] ra;
      logic [63:0] rb;
      logic [3:0]  rop;
      logic        rr;
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      rop = 4'($urandom_range(0, 15));
      rr  = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 3) == 0) rb = ra;
      step("rand", rr, rop, ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
